sram_1r1w_arbiter: RTL and testbench
====================================

# sram_1r1w_arbiter

Controller that owns a single 1024×11 one-read/one-write SRAM macro, with a registered read address and the write committing at the clock edge. It shares the macro's read port between two requesters by round-robin arbitration and passes a single write requester through to the write port. After reset or on request, it runs a zero-fill sweep, so the array never returns uninitialised contents. It sits between the predictor/table logic and the macro, and is the only block that drives the macro's ports.

## Interface
- ADDR_W, 10, address width
- DATA_W, 11, data width
- DEPTH, 1024, entries (2^ADDR_W)
- clock  in  1  sole clock; also drives the macro's R0_clk/W0_clk
- reset  in  1  asynchronous, active-high
- init_req  in  1  single-cycle pulse; restarts the zero-fill sweep
- init_busy  out  1  high while the sweep runs
- rd0_req_valid / rd0_req_ready  in / out  1  read requester 0 handshake
- rd0_req_addr  in  ADDR_W  read address
- rd0_resp_valid  out  1  one-cycle response pulse; no backpressure
- rd0_resp_data  out  DATA_W  response data
- rd1_*  (same set)  read requester 1
- wr_valid / wr_ready  in / out  1  write handshake
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- mem_ren, mem_raddr  out  1, ADDR_W  to macro R0_en, R0_addr
- mem_rdata  in  DATA_W  from macro R0_data
- mem_wen, mem_waddr, mem_wdata  out  1, ADDR_W, DATA_W  to macro W0_*

## Operation
- State machine, two states: INIT, RUN.
  - Reset enters INIT.
  - INIT → RUN after the write to address DEPTH-1.
  - init_req in RUN → INIT at the next edge.
  - init_req in INIT restarts the sweep counter at 0.
- INIT:
  - Each cycle: mem_wen=1, mem_waddr=sweep counter, mem_wdata=0; counter increments.
  - init_busy=1; all *_req_ready=0, wr_ready=0; mem_ren=0.
- RUN, writes: wr_ready=1. mem_wen = wr_valid, and mem_waddr/mem_wdata are wired from wr_addr/wr_data.
- RUN, read arbitration:
  - Round-robin pointer rr: 0 favours rd0, 1 favours rd1.
  - If both requesters are valid, the favoured one is granted.
  - If one is valid, it is granted.
  - On any grant, rr = ~granted index.
  - rdX_req_ready = grant_X. Ready depends combinationally on valid; requesters must not depend on ready to assert valid.
  - mem_ren = any grant; mem_raddr = granted address.
- Response path:
  - Register granted index, addr and valid; rdX_resp_valid pulses the next cycle for the granted X.
  - Data = mem_rdata, unless a write was accepted in the grant cycle to the same address. In that case the registered wr_data is returned (same-address read-during-write bypass).
- A read granted in the final RUN cycle before an init_req-induced INIT still delivers its response in the first INIT cycle.

## Timing
- Reset values: init_busy=1, sweep counter=0, rr=0, all resp_valid=0, resp_data=0, all ready=0, mem_ren=0, mem_wen=0 while reset is asserted.
- Sweep: cycles 0..1023 after reset release; init_busy falls at cycle 1024, when the first request can be accepted.
- Read latency: request accepted at edge T, response valid during cycle T+1. Throughput is one read per cycle total.
- Write: accepted at edge T, visible to reads granted at T (via bypass) and after.
- Sweep counter: ADDR_W bits; its wrap from DEPTH-1 to 0 coincides with the INIT → RUN transition.
- Reset asserted mid-sweep or mid-read: returns to INIT, counter=0, in-flight response dropped (resp_valid=0).

## Test plan
- Reset, hold both reads valid → init_busy=1 for exactly 1024 cycles; mem_wen with data 0 for addresses 0..1023 in order; first grant at cycle 1024 goes to rd0.
- Write 0x5A5 to addr 3, then rd0 read of addr 3 → rd0_resp_valid one cycle after grant, data 0x5A5; the rd1 response stays 0.
- Both requesters valid for 6 cycles → grants alternate rd0, rd1, rd0, rd1, rd0, rd1; responses tagged to the correct port.
- Write 0x7FF to addr 10 while rd1 reads addr 10 in the same cycle → rd1_resp_data=0x7FF.
- init_req while rd0 has just been granted → rd0 response still delivered; then init_busy=1 for 1024 cycles; a later read of addr 3 returns 0.
- Reset asserted at sweep address 500 → counter restarts at 0 and the full 1024-cycle sweep repeats.

Source files
------------

// File: rtl/sram_1r1w_arbiter_if.sv
// Requester-side bundle of the 1R1W SRAM controller:
// init control, two read ports and one write port.
interface sram_1r1w_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 11
) ();

    logic              init_req;
    logic              init_busy;

    logic              rd0_req_valid;
    logic              rd0_req_ready;
    logic [ADDR_W-1:0] rd0_req_addr;
    logic              rd0_resp_valid;
    logic [DATA_W-1:0] rd0_resp_data;

    logic              rd1_req_valid;
    logic              rd1_req_ready;
    logic [ADDR_W-1:0] rd1_req_addr;
    logic              rd1_resp_valid;
    logic [DATA_W-1:0] rd1_resp_data;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output init_req,
        input  init_busy,
        output rd0_req_valid,
        input  rd0_req_ready,
        output rd0_req_addr,
        input  rd0_resp_valid,
        input  rd0_resp_data,
        output rd1_req_valid,
        input  rd1_req_ready,
        output rd1_req_addr,
        input  rd1_resp_valid,
        input  rd1_resp_data,
        output wr_valid,
        input  wr_ready,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  init_req,
        output init_busy,
        input  rd0_req_valid,
        output rd0_req_ready,
        input  rd0_req_addr,
        output rd0_resp_valid,
        output rd0_resp_data,
        input  rd1_req_valid,
        output rd1_req_ready,
        input  rd1_req_addr,
        output rd1_resp_valid,
        output rd1_resp_data,
        input  wr_valid,
        output wr_ready,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/sram_1r1w_arbiter.sv
// Owner of a 1R1W SRAM macro: zero-fill sweep, round-robin
// sharing of the read port, write pass-through with RAW bypass.
module sram_1r1w_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 11,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    sram_1r1w_arbiter_if.slave bus,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] SWEEP_ONE  = ADDR_W'(1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] sweep;
    logic              run;
    logic              rr;

    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic [ADDR_W-1:0] gnt_addr;
    logic              wr_fire;

    logic              resp_vld;
    logic              resp_idx;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic [DATA_W-1:0] resp_data;

    assign run = (state == ST_RUN);

    // Round-robin grant; a lone requester always wins.
    always_comb begin
        gnt0     = run && bus.rd0_req_valid
                 && (!bus.rd1_req_valid || !rr);
        gnt1     = run && bus.rd1_req_valid
                 && (!bus.rd0_req_valid || rr);
        gnt_any  = gnt0 || gnt1;
        gnt_addr = gnt1 ? bus.rd1_req_addr
                        : bus.rd0_req_addr;
        wr_fire  = run && bus.wr_valid;
    end

    assign bus.rd0_req_ready = gnt0;
    assign bus.rd1_req_ready = gnt1;
    assign bus.wr_ready      = run;
    assign bus.init_busy     = !run;

    // Macro port muxing: sweep owns the write port during INIT.
    always_comb begin
        mem_ren   = gnt_any;
        mem_raddr = gnt_addr;
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        unique case (state)
            ST_INIT: begin
                mem_wen   = !reset;
                mem_waddr = sweep;
                mem_wdata = '0;
            end
            ST_RUN: begin
                mem_wen   = bus.wr_valid;
                mem_waddr = bus.wr_addr;
                mem_wdata = bus.wr_data;
            end
            default: begin
                mem_wen   = 1'b0;
                mem_waddr = '0;
                mem_wdata = '0;
            end
        endcase
    end

    // INIT/RUN control and sweep counter; the counter wraps
    // to 0 on the same edge that leaves INIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
            sweep <= '0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    if (bus.init_req) begin
                        sweep <= '0;
                    end else begin
                        sweep <= sweep + SWEEP_ONE;
                        if (sweep == SWEEP_LAST) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.init_req) begin
                        state <= ST_INIT;
                        sweep <= '0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    sweep <= '0;
                end
            endcase
        end
    end

    // Round-robin pointer moves away from the last winner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr <= 1'b0;
        end else if (gnt0) begin
            rr <= 1'b1;
        end else if (gnt1) begin
            rr <= 1'b0;
        end
    end

    // Response tag and same-address write bypass, captured
    // in the grant cycle to line up with macro read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_vld <= 1'b0;
            resp_idx <= 1'b0;
            byp_hit  <= 1'b0;
            byp_data <= '0;
        end else begin
            resp_vld <= gnt_any;
            resp_idx <= gnt1;
            byp_hit  <= gnt_any && wr_fire
                      && (bus.wr_addr == gnt_addr);
            byp_data <= bus.wr_data;
        end
    end

    assign resp_data = byp_hit ? byp_data : mem_rdata;

    assign bus.rd0_resp_valid = resp_vld && !resp_idx;
    assign bus.rd1_resp_valid = resp_vld && resp_idx;

    assign bus.rd0_resp_data = bus.rd0_resp_valid
                             ? resp_data : '0;
    assign bus.rd1_resp_data = bus.rd1_resp_valid
                             ? resp_data : '0;

endmodule

// File: tb/tb_sram_1r1w_arbiter.sv
// Scoreboard bench for sram_1r1w_arbiter with a behavioural
// 1R1W macro (registered read, write at the edge).
module tb_sram_1r1w_arbiter;

    localparam int AW = 10;
    localparam int DW = 11;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    sram_1r1w_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    sram_1r1w_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    // Macro model: junk power-up contents, read-before-write.
    logic [DW-1:0] mem [1024];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 11'h155;
        mem_rdata = 11'h2AA;
    end

    always @(posedge clock) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_raddr];
    end

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: reset/sweep outputs and scoreboard pops.
    logic [AW-1:0] exp_sweep = '0;
    exp_t          e;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_sweep = '0;
                chk("reset_outputs",
                    {bus.init_busy, bus.rd0_req_ready, bus.rd1_req_ready,
                     bus.wr_ready, mem_ren, mem_wen,
                     bus.rd0_resp_valid, bus.rd1_resp_valid},
                    8'b1000_0000);
                chk("reset_resp_data",
                    {bus.rd0_resp_data, bus.rd1_resp_data}, 0);
            end else if (bus.init_busy) begin
                chk("sweep_wen", mem_wen, 1);
                chk("sweep_addr", mem_waddr, exp_sweep);
                chk("sweep_data", mem_wdata, 0);
                chk("init_ready",
                    {bus.rd0_req_ready, bus.rd1_req_ready,
                     bus.wr_ready, mem_ren}, 0);
                exp_sweep = exp_sweep + 1'b1;
            end
            if (bus.rd0_resp_valid && bus.rd1_resp_valid) begin
                chk("both_resp_valid", 1, 0);
            end else if (bus.rd0_resp_valid || bus.rd1_resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_port", bus.rd1_resp_valid, e.port);
                    if (bus.rd1_resp_valid) begin
                        chk("resp_data_rd1", bus.rd1_resp_data, e.data);
                        chk("idle_data_rd0", bus.rd0_resp_data, 0);
                    end else begin
                        chk("resp_data_rd0", bus.rd0_resp_data, e.data);
                        chk("idle_data_rd1", bus.rd1_resp_data, 0);
                    end
                end
            end
        end
    end

    task automatic drive(
        input logic v0, input logic [AW-1:0] a0,
        input logic v1, input logic [AW-1:0] a1,
        input logic wv, input logic [AW-1:0] wa,
        input logic [DW-1:0] wd
    );
        bus.rd0_req_valid = v0;
        bus.rd0_req_addr  = a0;
        bus.rd1_req_valid = v1;
        bus.rd1_req_addr  = a1;
        bus.wr_valid      = wv;
        bus.wr_addr       = wa;
        bus.wr_data       = wd;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        bus.init_req = 1'b0;
    endtask

    // Called at a negedge with inputs already driven.
    task automatic expect_grant(
        input string name, input logic g0, input logic g1,
        input logic [DW-1:0] d
    );
        #1;
        chk(name, {bus.rd0_req_ready, bus.rd1_req_ready}, {g0, g1});
        if (g0 || g1) sb.push_back({g1, d});
        @(negedge clock);
    endtask

    task automatic write_cycle(
        input logic [AW-1:0] a, input logic [DW-1:0] d
    );
        drive(1'b0, '0, 1'b0, '0, 1'b1, a, d);
        #1;
        chk("wr_ready", bus.wr_ready, 1);
        @(negedge clock);
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (bus.init_busy && n < 2000) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    int n;
    int k;

    initial begin
        idle();
        drive(1'b1, 10'd5, 1'b1, 10'd6, 1'b0, '0, '0);
        repeat (3) @(negedge clock);
        release_reset();
        wait_busy(n);
        chk("sweep_len_reset", n, 1024);

        // First RUN cycle, both valid, rr=0 -> rd0.
        expect_grant("first_grant", 1'b1, 1'b0, 11'h000);

        write_cycle(10'd3, 11'h5A5);
        write_cycle(10'd4, 11'h0F0);

        drive(1'b1, 10'd3, 1'b0, '0, 1'b0, '0, '0);
        expect_grant("rd0_after_write", 1'b1, 1'b0, 11'h5A5);
        drive(1'b0, '0, 1'b1, 10'd4, 1'b0, '0, '0);
        expect_grant("rd1_single", 1'b0, 1'b1, 11'h0F0);

        drive(1'b1, 10'd3, 1'b1, 10'd4, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            expect_grant("alternate", (i % 2) == 0, (i % 2) == 1,
                         (i % 2) == 0 ? 11'h5A5 : 11'h0F0);
        end

        drive(1'b0, '0, 1'b1, 10'd10, 1'b1, 10'd10, 11'h7FF);
        expect_grant("rd1_bypass", 1'b0, 1'b1, 11'h7FF);
        drive(1'b1, 10'd10, 1'b0, '0, 1'b1, 10'd11, 11'h001);
        expect_grant("rd0_no_bypass", 1'b1, 1'b0, 11'h7FF);
        drive(1'b0, '0, 1'b1, 10'd11, 1'b0, '0, '0);
        expect_grant("rd1_addr11", 1'b0, 1'b1, 11'h001);

        // init_req with a read granted in the same cycle.
        drive(1'b1, 10'd3, 1'b0, '0, 1'b0, '0, '0);
        bus.init_req = 1'b1;
        expect_grant("rd0_before_init", 1'b1, 1'b0, 11'h5A5);
        idle();
        wait_busy(n);
        chk("sweep_len_init_req", n, 1024);
        drive(1'b1, 10'd3, 1'b0, '0, 1'b0, '0, '0);
        expect_grant("rd0_after_init", 1'b1, 1'b0, 11'h000);

        // Reset with a response in flight drops it.
        drive(1'b0, '0, 1'b1, 10'd4, 1'b0, '0, '0);
        #1;
        chk("rd1_ready_pre_reset", bus.rd1_req_ready, 1);
        @(posedge clock);
        #1 reset = 1'b1;
        idle();
        @(negedge clock);
        chk("dropped_resp",
            {bus.rd0_resp_valid, bus.rd1_resp_valid}, 0);
        repeat (2) @(negedge clock);
        release_reset();
        wait_busy(n);
        chk("sweep_len_read_reset", n, 1024);

        // Reset in the middle of a sweep restarts it.
        bus.init_req = 1'b1;
        @(negedge clock);
        bus.init_req = 1'b0;
        k = 0;
        while (!(bus.init_busy && mem_waddr == 10'd500) && k < 2000) begin
            k++;
            @(negedge clock);
        end
        chk("reach_addr_500", mem_waddr, 500);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        release_reset();
        wait_busy(n);
        chk("sweep_len_mid_reset", n, 1024);

        drive(1'b0, '0, 1'b1, 10'd11, 1'b0, '0, '0);
        expect_grant("rd1_after_mid_reset", 1'b0, 1'b1, 11'h000);
        idle();
        repeat (2) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
